// File: rtl/gen_que_wr_arb.sv
// Round-robin burst arbiter driving the write side (push/din) of one gen_async_que.
// Optional stall timeout is compiled in with `define GEN_QUE_WR_ARB_TIMEOUT_EN.
module gen_que_wr_arb #(
  parameter int NREQ     = 4,
  parameter int WD       = 32,
  parameter int MAXBURST = 16,
  parameter int TO_CYC   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_last,
  input  logic [NREQ*WD-1:0]      req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic                    push,
  output logic [WD-1:0]           din,
  input  logic                    qfull,
  input  logic                    q_afull,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    timeout_evt
);

  localparam int IW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST) + 1;

  if (NREQ < 2 || NREQ > 16 || MAXBURST < 2 || MAXBURST > 256 || TO_CYC < 2) begin : g_param_err
    $error("gen_que_wr_arb: parameter out of range");
  end

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   grant_id_q, grant_id_d;
  logic [IW-1:0]   pick;
  logic            busy_q, busy_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            found;
  logic            beat_acc;
  logic            burst_end;

`ifdef GEN_QUE_WR_ARB_TIMEOUT_EN
  localparam int SW = $clog2(TO_CYC) + 1;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            timeout_q, timeout_d;
`endif

  // First valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx   = 0;
    pick  = rr_ptr_q;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
  end

  assign beat_acc = (state_q == XFER) && req_valid[grant_id_q] && !qfull;

  // Next-state process.
  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path infers a latch.
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    busy_d     = busy_q;
    beat_cnt_d = beat_cnt_q;
    burst_end  = 1'b0;
`ifdef GEN_QUE_WR_ARB_TIMEOUT_EN
    stall_cnt_d = stall_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (found && !q_afull) begin
          state_d    = XFER;
          grant_id_d = pick;
          busy_d     = 1'b1;
          beat_cnt_d = '0;
`ifdef GEN_QUE_WR_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      XFER: begin
        if (beat_acc) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          burst_end  = req_last[grant_id_q] || (beat_cnt_q == BW'(MAXBURST - 1));
`ifdef GEN_QUE_WR_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
        end else if (!req_valid[grant_id_q]) begin
          // Only an absent requester counts as a stall; FIFO backpressure never times out.
          if (stall_cnt_q == SW'(TO_CYC - 1)) begin
            burst_end = 1'b1;
            timeout_d = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
`endif
        end
        if (burst_end) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          rr_ptr_d = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      busy_q     <= busy_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef GEN_QUE_WR_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end
  assign timeout_evt = timeout_q;
`else
  assign timeout_evt = 1'b0;
`endif

  // Output process: the FIFO-facing pins follow the current grant combinationally.
  always_comb begin
    req_ready = '0;
    push      = 1'b0;
    din       = req_data[grant_id_q*WD +: WD];
    if (!rst && state_q == XFER) begin
      req_ready[grant_id_q] = !qfull;
      push                  = beat_acc;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_gen_que_wr_arb.sv
// Directed, table-driven bench for gen_que_wr_arb (NREQ=4, WD=32, MAXBURST=16, TO_CYC=64).
module tb_gen_que_wr_arb;

  localparam int NREQ = 4;
  localparam int WD   = 32;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*WD-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 push;
  logic [WD-1:0]        din;
  logic                 qfull;
  logic                 q_afull;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_evt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gen_que_wr_arb #(.NREQ(NREQ), .WD(WD), .MAXBURST(16), .TO_CYC(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .push(push), .din(din),
    .qfull(qfull), .q_afull(q_afull),
    .grant_id(grant_id), .busy(busy), .timeout_evt(timeout_evt)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        qf;
    logic        af;
    int          lane;
    logic [31:0] dat;
    logic [3:0]  e_ready;
    logic        e_push;
    logic [31:0] e_din;
    logic [1:0]  e_gid;
    logic        e_busy;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input string nm, input logic r, input logic [3:0] v, input logic [3:0] l,
                              input logic qf, input logic af, input int lane, input logic [31:0] dat,
                              input logic [3:0] er, input logic ep, input logic [31:0] ed,
                              input logic [1:0] eg, input logic eb);
    vec_t x;
    x.name = nm; x.rst = r; x.valid = v; x.last = l; x.qf = qf; x.af = af;
    x.lane = lane; x.dat = dat; x.e_ready = er; x.e_push = ep; x.e_din = ed;
    x.e_gid = eg; x.e_busy = eb;
    vq.push_back(x);
  endfunction

  // Non-selected lanes carry a recognisable filler so a wrong din mux shows up.
  task automatic drive(input logic r, input logic [3:0] v, input logic [3:0] l,
                       input logic qf, input logic af, input int lane, input logic [31:0] dat);
    rst = r; req_valid = v; req_last = l; qfull = qf; q_afull = af;
    for (int i = 0; i < NREQ; i++)
      req_data[i*WD +: WD] = (i == lane) ? dat : (32'hDEAD_0000 | 32'(i));
  endtask

  task automatic chk_outs(input string nm, input logic [3:0] er, input logic ep, input logic [31:0] ed,
                          input logic [1:0] eg, input logic eb, input logic et);
    check({nm, ".ready"}, 32'(req_ready), 32'(er));
    check({nm, ".push"}, 32'(push), 32'(ep));
    if (ep) check({nm, ".din"}, din, ed);
    check({nm, ".gid"}, 32'(grant_id), 32'(eg));
    check({nm, ".busy"}, 32'(busy), 32'(eb));
    check({nm, ".tevt"}, 32'(timeout_evt), 32'(et));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].valid, vq[i].last, vq[i].qf, vq[i].af, vq[i].lane, vq[i].dat);
      #3;
      chk_outs(vq[i].name, vq[i].e_ready, vq[i].e_push, vq[i].e_din, vq[i].e_gid, vq[i].e_busy, 1'b0);
      tick();
    end
    vq.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int n2;
    logic [1:0]  g;
    logic        idle;
    logic [1:0]  eg;
    logic [31:0] ed;

    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0);
    tick();
    tick();

    // reset, single requester, round-robin pointer after burst
    add("rst",        1, 4'hF,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    add("t1_arb",     0, 4'b0010, 4'h0,    0, 0, 1, 32'h10, 4'h0,    0, 32'h0,  0, 0);
    add("t1_b1",      0, 4'b0010, 4'h0,    0, 0, 1, 32'h10, 4'b0010, 1, 32'h10, 1, 1);
    add("t1_b2",      0, 4'b0010, 4'h0,    0, 0, 1, 32'h11, 4'b0010, 1, 32'h11, 1, 1);
    add("t1_b3",      0, 4'b0010, 4'h0,    0, 0, 1, 32'h12, 4'b0010, 1, 32'h12, 1, 1);
    add("t1_b4",      0, 4'b0010, 4'h0,    0, 0, 1, 32'h13, 4'b0010, 1, 32'h13, 1, 1);
    add("t1_b5",      0, 4'b0010, 4'b0010, 0, 0, 1, 32'h14, 4'b0010, 1, 32'h14, 1, 1);
    add("t1_done",    0, 4'h0,    4'h0,    0, 0, 1, 32'h00, 4'h0,    0, 32'h0,  1, 0);
    add("t1_rr_arb",  0, 4'b0011, 4'h0,    0, 0, 0, 32'h20, 4'h0,    0, 32'h0,  1, 0);
    add("t1_rr_g0",   0, 4'b0011, 4'b0001, 0, 0, 0, 32'h20, 4'b0001, 1, 32'h20, 0, 1);
    add("t1_rr_done", 0, 4'h0,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    // fairness: all valid, 2-beat bursts
    add("f_rst",      1, 4'hF,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    add("f_arb0",     0, 4'hF,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    add("f_g0a",      0, 4'hF,    4'h0,    0, 0, 0, 32'h30, 4'b0001, 1, 32'h30, 0, 1);
    add("f_g0b",      0, 4'hF,    4'b0001, 0, 0, 0, 32'h31, 4'b0001, 1, 32'h31, 0, 1);
    add("f_arb1",     0, 4'hF,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    add("f_g1a",      0, 4'hF,    4'h0,    0, 0, 1, 32'h32, 4'b0010, 1, 32'h32, 1, 1);
    add("f_g1b",      0, 4'hF,    4'b0010, 0, 0, 1, 32'h33, 4'b0010, 1, 32'h33, 1, 1);
    add("f_arb2",     0, 4'hF,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  1, 0);
    add("f_g2a",      0, 4'hF,    4'h0,    0, 0, 2, 32'h34, 4'b0100, 1, 32'h34, 2, 1);
    add("f_g2b",      0, 4'hF,    4'b0100, 0, 0, 2, 32'h35, 4'b0100, 1, 32'h35, 2, 1);
    add("f_arb3",     0, 4'hF,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  2, 0);
    add("f_g3a",      0, 4'hF,    4'h0,    0, 0, 3, 32'h36, 4'b1000, 1, 32'h36, 3, 1);
    add("f_g3b",      0, 4'hF,    4'b1000, 0, 0, 3, 32'h37, 4'b1000, 1, 32'h37, 3, 1);
    add("f_arb4",     0, 4'hF,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  3, 0);
    add("f_g0c",      0, 4'hF,    4'h0,    0, 0, 0, 32'h38, 4'b0001, 1, 32'h38, 0, 1);
    add("f_g0d",      0, 4'hF,    4'b0001, 0, 0, 0, 32'h39, 4'b0001, 1, 32'h39, 0, 1);
    add("f_done",     0, 4'h0,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    // backpressure: qfull on burst cycles 3-6, q_afull mid-burst and in IDLE
    add("bp_arb",     0, 4'b0100, 4'h0,    0, 0, 2, 32'h40, 4'h0,    0, 32'h0,  0, 0);
    add("bp_b1",      0, 4'b0100, 4'h0,    0, 0, 2, 32'h40, 4'b0100, 1, 32'h40, 2, 1);
    add("bp_b2",      0, 4'b0100, 4'h0,    0, 0, 2, 32'h41, 4'b0100, 1, 32'h41, 2, 1);
    add("bp_s3",      0, 4'b0100, 4'h0,    1, 0, 2, 32'h42, 4'h0,    0, 32'h0,  2, 1);
    add("bp_s4",      0, 4'b0100, 4'h0,    1, 0, 2, 32'h42, 4'h0,    0, 32'h0,  2, 1);
    add("bp_s5",      0, 4'b0100, 4'h0,    1, 0, 2, 32'h42, 4'h0,    0, 32'h0,  2, 1);
    add("bp_s6",      0, 4'b0100, 4'h0,    1, 0, 2, 32'h42, 4'h0,    0, 32'h0,  2, 1);
    add("bp_b3",      0, 4'b0100, 4'h0,    0, 0, 2, 32'h42, 4'b0100, 1, 32'h42, 2, 1);
    add("bp_b4",      0, 4'b0100, 4'h0,    0, 0, 2, 32'h43, 4'b0100, 1, 32'h43, 2, 1);
    add("bp_b5",      0, 4'b0100, 4'h0,    0, 1, 2, 32'h44, 4'b0100, 1, 32'h44, 2, 1);
    add("bp_b6",      0, 4'b0100, 4'h0,    0, 1, 2, 32'h45, 4'b0100, 1, 32'h45, 2, 1);
    add("bp_b7",      0, 4'b0100, 4'h0,    0, 1, 2, 32'h46, 4'b0100, 1, 32'h46, 2, 1);
    add("bp_b8",      0, 4'b0100, 4'b0100, 0, 1, 2, 32'h47, 4'b0100, 1, 32'h47, 2, 1);
    add("bp_af1",     0, 4'b0100, 4'h0,    0, 1, 2, 32'h48, 4'h0,    0, 32'h0,  2, 0);
    add("bp_af2",     0, 4'b0100, 4'h0,    0, 1, 2, 32'h48, 4'h0,    0, 32'h0,  2, 0);
    add("bp_arb2",    0, 4'b0100, 4'h0,    0, 0, 2, 32'h48, 4'h0,    0, 32'h0,  2, 0);
    add("bp_lastq",   0, 4'b0100, 4'b0100, 1, 0, 2, 32'h48, 4'h0,    0, 32'h0,  2, 1);
    add("bp_lasta",   0, 4'b0100, 4'b0100, 0, 0, 2, 32'h48, 4'b0100, 1, 32'h48, 2, 1);
    add("bp_done",    0, 4'h0,    4'h0,    0, 0, 2, 32'h00, 4'h0,    0, 32'h0,  2, 0);
    run_table();

    // MAXBURST cap: req0 has 20 beats, req2 has 3; expect 16 / 3 / 4 split
    n0 = 0;
    n2 = 0;
    for (int c = 0; c <= 26; c++) begin
      drive(1'b0, {1'b0, (n2 < 3), 1'b0, (n0 < 20)}, {1'b0, (n2 == 2), 1'b0, (n0 == 19)},
            1'b0, 1'b0, 0, 32'h100 + 32'(n0));
      req_data[2*WD +: WD] = 32'h200 + 32'(n2);
      idle = (c == 0) || (c == 17) || (c == 21) || (c == 26);
      eg = 2'd0;
      if (idle) begin
        if (c == 0 || c == 21) eg = 2'd2;
      end else begin
        g  = (c <= 16 || c >= 22) ? 2'd0 : 2'd2;
        eg = g;
      end
      ed = (eg == 2'd0) ? 32'h100 + 32'(n0) : 32'h200 + 32'(n2);
      #3;
      chk_outs($sformatf("mb_c%0d", c), idle ? 4'h0 : 4'(1 << eg), !idle, ed, eg, !idle, 1'b0);
      if (!idle) begin
        if (eg == 2'd0) n0++;
        else            n2++;
      end
      tick();
    end

    // reset mid-burst, then arbitration restarts from rr_ptr=0; then grant req3 for the stall test
    add("rs_arb",     0, 4'b0010, 4'h0,    0, 0, 1, 32'h50, 4'h0,    0, 32'h0,  0, 0);
    add("rs_b1",      0, 4'b0010, 4'h0,    0, 0, 1, 32'h50, 4'b0010, 1, 32'h50, 1, 1);
    add("rs_b2",      0, 4'b0010, 4'h0,    0, 0, 1, 32'h51, 4'b0010, 1, 32'h51, 1, 1);
    add("rs_b3",      0, 4'b0010, 4'h0,    0, 0, 1, 32'h52, 4'b0010, 1, 32'h52, 1, 1);
    add("rs_rst",     1, 4'b0010, 4'h0,    0, 0, 1, 32'h53, 4'h0,    0, 32'h0,  1, 1);
    add("rs_after",   0, 4'h0,    4'h0,    0, 0, 1, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    add("rs_arb2",    0, 4'b0011, 4'h0,    0, 0, 0, 32'h60, 4'h0,    0, 32'h0,  0, 0);
    add("rs_g0",      0, 4'b0011, 4'b0001, 0, 0, 0, 32'h60, 4'b0001, 1, 32'h60, 0, 1);
    add("rs_done",    0, 4'h0,    4'h0,    0, 0, 0, 32'h00, 4'h0,    0, 32'h0,  0, 0);
    add("to_arb",     0, 4'b1000, 4'h0,    0, 0, 3, 32'h70, 4'h0,    0, 32'h0,  0, 0);
    add("to_b1",      0, 4'b1000, 4'h0,    0, 0, 3, 32'h70, 4'b1000, 1, 32'h70, 3, 1);
    add("to_b2",      0, 4'b1000, 4'h0,    0, 0, 3, 32'h71, 4'b1000, 1, 32'h71, 3, 1);
    run_table();

`ifdef GEN_QUE_WR_ARB_TIMEOUT_EN
    for (int s = 1; s <= 64; s++) begin
      drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0);
      #3;
      check($sformatf("to_stall%0d.busy", s), 32'(busy), 32'd1);
      check($sformatf("to_stall%0d.tevt", s), 32'(timeout_evt), 32'd0);
      tick();
    end
    drive(1'b0, 4'b0001, 4'h0, 1'b0, 1'b0, 0, 32'h80);
    #3;
    chk_outs("to_fire", 4'h0, 1'b0, 32'h0, 2'd3, 1'b0, 1'b1);
    tick();
    drive(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 0, 32'h80);
    #3;
    chk_outs("to_next", 4'b0001, 1'b1, 32'h80, 2'd0, 1'b1, 1'b0);
    tick();
`else
    for (int s = 1; s <= 100; s++) begin
      drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 0, 32'h0);
      #3;
      check($sformatf("hold%0d.busy", s), 32'(busy), 32'd1);
      check($sformatf("hold%0d.tevt", s), 32'(timeout_evt), 32'd0);
      check($sformatf("hold%0d.gid", s), 32'(grant_id), 32'd3);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
